// File: rtl/trap_pkg.sv
// rtl/trap_pkg.sv - shared constants and types for the machine-mode trap sequencer
package trap_pkg;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;

   localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
   localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
   localparam logic [31:0] INST_MRET   = 32'h3020_0073;

   localparam logic [31:0] CAUSE_ECALL  = 32'd11;
   localparam logic [31:0] CAUSE_EBREAK = 32'd3;
   localparam logic [31:0] CAUSE_TIMER  = 32'h8000_0007;
   localparam logic [31:0] CAUSE_EXT    = 32'h8000_000B;

   localparam int MSTATUS_MIE  = 3;
   localparam int MSTATUS_MPIE = 7;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MEPC,
      S_MSTATUS,
      S_MCAUSE,
      S_MRET,
      S_ASSERT
   } trap_state_e;

   typedef enum logic [1:0] {
      EV_NONE,
      EV_SYNC,
      EV_MRET,
      EV_ASYNC
   } trap_event_e;

endpackage

// File: rtl/trap_cause_enc.sv
// rtl/trap_cause_enc.sv - classifies the pending event and forms its cause and return PC
module trap_cause_enc
   import trap_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int INT_W = 8
) (
   input  logic [XLEN-1:0]  inst_i,
   input  logic [XLEN-1:0]  inst_addr_i,
   input  logic             jump_flag_i,
   input  logic [XLEN-1:0]  jump_addr_i,
   input  logic [INT_W-1:0] int_flag_i,
   input  logic             mie_i,
   output trap_event_e      event_o,
   output logic [XLEN-1:0]  cause_o,
   output logic [XLEN-1:0]  epc_o
);

   always_comb begin
      event_o = EV_NONE;
      cause_o = '0;
      epc_o   = inst_addr_i;
      // Fixed priority: synchronous exception, then mret, then interrupt.
      if (inst_i == INST_ECALL) begin
         event_o = EV_SYNC;
         cause_o = CAUSE_ECALL;
      end else if (inst_i == INST_EBREAK) begin
         event_o = EV_SYNC;
         cause_o = CAUSE_EBREAK;
      end else if (inst_i == INST_MRET) begin
         event_o = EV_MRET;
      end else if ((|int_flag_i) && mie_i) begin
         event_o = EV_ASYNC;
         cause_o = int_flag_i[0] ? CAUSE_TIMER : CAUSE_EXT;
         // A redirect in flight means inst_i will never retire; resume at the target.
         epc_o   = jump_flag_i ? jump_addr_i : inst_addr_i;
      end
   end

endmodule

// File: rtl/trap_unit.sv
// rtl/trap_unit.sv - trap entry / mret sequencer: holds the pipeline, writes CSRs, redirects ex
module trap_unit
   import trap_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int CSR_AW = 12,
   parameter int INT_W  = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [XLEN-1:0]   inst_i,
   input  logic [XLEN-1:0]   inst_addr_i,
   input  logic              jump_flag_i,
   input  logic [XLEN-1:0]   jump_addr_i,
   input  logic [INT_W-1:0]  int_flag_i,
   input  logic [XLEN-1:0]   csr_mtvec_i,
   input  logic [XLEN-1:0]   csr_mepc_i,
   input  logic [XLEN-1:0]   csr_mstatus_i,
   output logic              hold_flag_o,
   output logic              csr_we_o,
   output logic [CSR_AW-1:0] csr_waddr_o,
   output logic [XLEN-1:0]   csr_wdata_o,
   output logic              int_assert_o,
   output logic [XLEN-1:0]   int_addr_o
);

   trap_state_e       state_q, state_d;
   trap_event_e       enc_event;
   logic [XLEN-1:0]   enc_cause, enc_epc;
   logic [XLEN-1:0]   cause_q, epc_q;
   logic              accept;

   logic              we_d, assert_d;
   logic [CSR_AW-1:0] waddr_d;
   logic [XLEN-1:0]   wdata_d, addr_d;
   logic [XLEN-1:0]   mstatus_trap, mstatus_mret;

   trap_cause_enc #(
      .XLEN  (XLEN),
      .INT_W (INT_W)
   ) u_cause_enc (
      .inst_i      (inst_i),
      .inst_addr_i (inst_addr_i),
      .jump_flag_i (jump_flag_i),
      .jump_addr_i (jump_addr_i),
      .int_flag_i  (int_flag_i),
      .mie_i       (csr_mstatus_i[MSTATUS_MIE]),
      .event_o     (enc_event),
      .cause_o     (enc_cause),
      .epc_o       (enc_epc)
   );

   // Gated by reset so hold drops immediately when reset is asserted.
   assign accept      = (state_q == S_IDLE) && (enc_event != EV_NONE) && !rst_i;
   assign hold_flag_o = accept || (state_q != S_IDLE) || int_assert_o;

   always_comb begin
      mstatus_trap               = csr_mstatus_i;
      mstatus_trap[MSTATUS_MPIE] = csr_mstatus_i[MSTATUS_MIE];
      mstatus_trap[MSTATUS_MIE]  = 1'b0;
      mstatus_mret               = csr_mstatus_i;
      mstatus_mret[MSTATUS_MIE]  = csr_mstatus_i[MSTATUS_MPIE];
      mstatus_mret[MSTATUS_MPIE] = 1'b1;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = (enc_event == EV_MRET) ? S_MRET : S_MEPC;
            end
         end
         S_MEPC:    state_d = S_MSTATUS;
         S_MSTATUS: state_d = S_MCAUSE;
         S_MCAUSE:  state_d = S_ASSERT;
         S_MRET:    state_d = S_ASSERT;
         S_ASSERT:  state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // Outputs are registered from the next state so each one lines up with its state cycle.
   always_comb begin
      we_d     = 1'b0;
      waddr_d  = '0;
      wdata_d  = '0;
      assert_d = 1'b0;
      addr_d   = '0;
      case (state_d)
         S_MEPC: begin
            we_d    = 1'b1;
            waddr_d = CSR_MEPC;
            wdata_d = (state_q == S_IDLE) ? enc_epc : epc_q;
         end
         S_MSTATUS: begin
            we_d    = 1'b1;
            waddr_d = CSR_MSTATUS;
            wdata_d = mstatus_trap;
         end
         S_MCAUSE: begin
            we_d    = 1'b1;
            waddr_d = CSR_MCAUSE;
            wdata_d = cause_q;
         end
         S_MRET: begin
            we_d    = 1'b1;
            waddr_d = CSR_MSTATUS;
            wdata_d = mstatus_mret;
         end
         S_ASSERT: begin
            assert_d = 1'b1;
            addr_d   = (state_q == S_MRET) ? csr_mepc_i : csr_mtvec_i;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= S_IDLE;
         cause_q      <= '0;
         epc_q        <= '0;
         csr_we_o     <= 1'b0;
         csr_waddr_o  <= '0;
         csr_wdata_o  <= '0;
         int_assert_o <= 1'b0;
         int_addr_o   <= '0;
      end else begin
         state_q      <= state_d;
         csr_we_o     <= we_d;
         csr_waddr_o  <= waddr_d;
         csr_wdata_o  <= wdata_d;
         int_assert_o <= assert_d;
         int_addr_o   <= addr_d;
         if (accept) begin
            cause_q <= enc_cause;
            epc_q   <= enc_epc;
         end
      end
   end

endmodule

// File: tb/tb_trap_unit.sv
// tb/tb_trap_unit.sv - directed table-driven bench for trap_unit
module tb_trap_unit;

   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam logic [31:0] ECALL  = 32'h0000_0073;
   localparam logic [31:0] EBREAK = 32'h0010_0073;
   localparam logic [31:0] MRET   = 32'h3020_0073;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [31:0] inst_i, inst_addr_i, jump_addr_i;
   logic        jump_flag_i;
   logic [7:0]  int_flag_i;
   logic [31:0] csr_mtvec_i, csr_mepc_i, csr_mstatus_i;
   logic        hold_flag_o, csr_we_o, int_assert_o;
   logic [11:0] csr_waddr_o;
   logic [31:0] csr_wdata_o, int_addr_o;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
      logic        jf;
      logic [31:0] ja;
      logic [7:0]  intf;
      logic [31:0] mst;
      logic [31:0] mtvec;
      logic [31:0] mepc;
      logic        hold;
      logic        we;
      logic [11:0] waddr;
      logic [31:0] wdata;
      logic        asrt;
      logic [31:0] iaddr;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;

   trap_unit dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .inst_i        (inst_i),
      .inst_addr_i   (inst_addr_i),
      .jump_flag_i   (jump_flag_i),
      .jump_addr_i   (jump_addr_i),
      .int_flag_i    (int_flag_i),
      .csr_mtvec_i   (csr_mtvec_i),
      .csr_mepc_i    (csr_mepc_i),
      .csr_mstatus_i (csr_mstatus_i),
      .hold_flag_o   (hold_flag_o),
      .csr_we_o      (csr_we_o),
      .csr_waddr_o   (csr_waddr_o),
      .csr_wdata_o   (csr_wdata_o),
      .int_assert_o  (int_assert_o),
      .int_addr_o    (int_addr_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic row(input logic [31:0] inst, pc, input logic jf, input logic [31:0] ja,
                      input logic [7:0] intf, input logic [31:0] mst, mtvec, mepc,
                      input logic hold, we, input logic [11:0] waddr, input logic [31:0] wdata,
                      input logic asrt, input logic [31:0] iaddr);
      vec_t v;
      v.inst = inst; v.pc = pc; v.jf = jf; v.ja = ja; v.intf = intf;
      v.mst = mst; v.mtvec = mtvec; v.mepc = mepc;
      v.hold = hold; v.we = we; v.waddr = waddr; v.wdata = wdata;
      v.asrt = asrt; v.iaddr = iaddr;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic [31:0] inst, pc, input logic jf, input logic [31:0] ja,
                        input logic [7:0] intf, input logic [31:0] mst);
      @(negedge clk_i);
      inst_i = inst; inst_addr_i = pc; jump_flag_i = jf; jump_addr_i = ja;
      int_flag_i = intf; csr_mstatus_i = mst;
      #1;
   endtask

   task automatic chk_all(input string tag, input logic hold, we, input logic [11:0] waddr,
                          input logic [31:0] wdata, input logic asrt, input logic [31:0] iaddr);
      chk({tag, ".hold"},  {31'b0, hold_flag_o},  {31'b0, hold});
      chk({tag, ".we"},    {31'b0, csr_we_o},     {31'b0, we});
      chk({tag, ".waddr"}, {20'b0, csr_waddr_o},  {20'b0, waddr});
      chk({tag, ".wdata"}, csr_wdata_o,           wdata);
      chk({tag, ".asrt"},  {31'b0, int_assert_o}, {31'b0, asrt});
      chk({tag, ".iaddr"}, int_addr_o,            iaddr);
   endtask

   initial begin
      int stray;
      rst_i = 1'b1;
      inst_i = NOP; inst_addr_i = '0; jump_flag_i = 1'b0; jump_addr_i = '0;
      int_flag_i = '0; csr_mtvec_i = 32'h400; csr_mepc_i = '0; csr_mstatus_i = '0;

      // ecall at 0x100
      row(ECALL, 32'h100, 0, 0, 8'h00, 32'h8, 32'h400, 0, 1, 0, 12'h000, 32'h0,   0, 32'h0);
      row(NOP,   32'h104, 0, 0, 8'h00, 32'h8, 32'h400, 0, 1, 1, 12'h341, 32'h100, 0, 32'h0);
      row(NOP,   32'h104, 0, 0, 8'h00, 32'h8, 32'h400, 0, 1, 1, 12'h300, 32'h80,  0, 32'h0);
      row(NOP,   32'h104, 0, 0, 8'h00, 32'h8, 32'h400, 0, 1, 1, 12'h342, 32'd11,  0, 32'h0);
      row(NOP,   32'h104, 0, 0, 8'h00, 32'h8, 32'h400, 0, 1, 0, 12'h000, 32'h0,   1, 32'h400);
      row(NOP,   32'h104, 0, 0, 8'h00, 32'h8, 32'h400, 0, 0, 0, 12'h000, 32'h0,   0, 32'h0);
      // timer interrupt during a redirect, then the same request with MIE clear
      row(NOP, 32'h300, 1, 32'h200, 8'h01, 32'h8, 32'h400, 0, 1, 0, 12'h000, 32'h0,         0, 32'h0);
      row(NOP, 32'h300, 0, 0,       8'h00, 32'h8, 32'h400, 0, 1, 1, 12'h341, 32'h200,       0, 32'h0);
      row(NOP, 32'h300, 0, 0,       8'h00, 32'h8, 32'h400, 0, 1, 1, 12'h300, 32'h80,        0, 32'h0);
      row(NOP, 32'h300, 0, 0,       8'h00, 32'h8, 32'h400, 0, 1, 1, 12'h342, 32'h8000_0007, 0, 32'h0);
      row(NOP, 32'h300, 0, 0,       8'h00, 32'h8, 32'h400, 0, 1, 0, 12'h000, 32'h0,         1, 32'h400);
      row(NOP, 32'h300, 0, 0,       8'h00, 32'h8, 32'h400, 0, 0, 0, 12'h000, 32'h0,         0, 32'h0);
      row(NOP, 32'h300, 1, 32'h200, 8'h01, 32'h0, 32'h400, 0, 0, 0, 12'h000, 32'h0,         0, 32'h0);
      row(NOP, 32'h300, 1, 32'h200, 8'h01, 32'h0, 32'h400, 0, 0, 0, 12'h000, 32'h0,         0, 32'h0);
      // mret
      row(MRET, 32'h700, 0, 0, 8'h00, 32'h80, 32'h400, 32'h104, 1, 0, 12'h000, 32'h0,  0, 32'h0);
      row(NOP,  32'h704, 0, 0, 8'h00, 32'h80, 32'h400, 32'h104, 1, 1, 12'h300, 32'h88, 0, 32'h0);
      row(NOP,  32'h704, 0, 0, 8'h00, 32'h80, 32'h400, 32'h104, 1, 0, 12'h000, 32'h0,  1, 32'h104);
      // ecall with a simultaneous interrupt, presented right after the mret strobe
      row(ECALL, 32'h800, 0, 0, 8'h02, 32'h8,  32'h400, 32'h104, 1, 0, 12'h000, 32'h0,   0, 32'h0);
      row(NOP,   32'h804, 0, 0, 8'h02, 32'h8,  32'h400, 32'h104, 1, 1, 12'h341, 32'h800, 0, 32'h0);
      row(NOP,   32'h804, 0, 0, 8'h02, 32'h8,  32'h400, 32'h104, 1, 1, 12'h300, 32'h80,  0, 32'h0);
      row(NOP,   32'h804, 0, 0, 8'h02, 32'h8,  32'h400, 32'h104, 1, 1, 12'h342, 32'd11,  0, 32'h0);
      row(NOP,   32'h804, 0, 0, 8'h02, 32'h8,  32'h400, 32'h104, 1, 0, 12'h000, 32'h0,   1, 32'h400);
      row(NOP,   32'h804, 0, 0, 8'h02, 32'h80, 32'h400, 32'h104, 0, 0, 12'h000, 32'h0,   0, 32'h0);
      // ebreak
      row(EBREAK, 32'h900, 0, 0, 8'h00, 32'h88, 32'h440, 0, 1, 0, 12'h000, 32'h0,   0, 32'h0);
      row(NOP,    32'h904, 0, 0, 8'h00, 32'h88, 32'h440, 0, 1, 1, 12'h341, 32'h900, 0, 32'h0);
      row(NOP,    32'h904, 0, 0, 8'h00, 32'h88, 32'h440, 0, 1, 1, 12'h300, 32'h80,  0, 32'h0);
      row(NOP,    32'h904, 0, 0, 8'h00, 32'h88, 32'h440, 0, 1, 1, 12'h342, 32'd3,   0, 32'h0);
      row(NOP,    32'h904, 0, 0, 8'h00, 32'h88, 32'h440, 0, 1, 0, 12'h000, 32'h0,   1, 32'h440);
      // external interrupt, no redirect in flight
      row(NOP, 32'hA00, 0, 32'h50, 8'h04, 32'h1808, 32'h400, 0, 1, 0, 12'h000, 32'h0,         0, 32'h0);
      row(NOP, 32'hA04, 0, 0,      8'h00, 32'h1808, 32'h400, 0, 1, 1, 12'h341, 32'hA00,       0, 32'h0);
      row(NOP, 32'hA04, 0, 0,      8'h00, 32'h1808, 32'h400, 0, 1, 1, 12'h300, 32'h1880,      0, 32'h0);
      row(NOP, 32'hA04, 0, 0,      8'h00, 32'h1808, 32'h400, 0, 1, 1, 12'h342, 32'h8000_000B, 0, 32'h0);
      row(NOP, 32'hA04, 0, 0,      8'h00, 32'h1808, 32'h400, 0, 1, 0, 12'h000, 32'h0,         1, 32'h400);
      row(NOP, 32'hA04, 0, 0,      8'h00, 32'h1880, 32'h400, 0, 0, 0, 12'h000, 32'h0,         0, 32'h0);

      // reset state
      @(negedge clk_i);
      @(negedge clk_i);
      inst_i = ECALL;
      #1;
      chk_all("reset", 0, 0, 12'h000, 32'h0, 0, 32'h0);
      inst_i = NOP;
      @(negedge clk_i);
      rst_i = 1'b0;

      foreach (vecs[i]) begin
         @(negedge clk_i);
         inst_i = vecs[i].inst; inst_addr_i = vecs[i].pc;
         jump_flag_i = vecs[i].jf; jump_addr_i = vecs[i].ja;
         int_flag_i = vecs[i].intf; csr_mstatus_i = vecs[i].mst;
         csr_mtvec_i = vecs[i].mtvec; csr_mepc_i = vecs[i].mepc;
         #1;
         chk_all($sformatf("vec%0d", i), vecs[i].hold, vecs[i].we, vecs[i].waddr,
                 vecs[i].wdata, vecs[i].asrt, vecs[i].iaddr);
      end

      // reset asserted while the mstatus write is on the port
      csr_mtvec_i = 32'h400;
      drive(ECALL, 32'h500, 0, 0, 8'h00, 32'h8);
      drive(NOP,   32'h504, 0, 0, 8'h00, 32'h8);
      chk("rst_seq.mepc_waddr", {20'b0, csr_waddr_o}, 32'h341);
      drive(NOP,   32'h504, 0, 0, 8'h00, 32'h8);
      chk("rst_seq.mstatus_waddr", {20'b0, csr_waddr_o}, 32'h300);
      rst_i = 1'b1;
      #1;
      chk_all("rst_mid", 0, 0, 12'h000, 32'h0, 0, 32'h0);
      drive(NOP, 32'h504, 0, 0, 8'h00, 32'h8);
      rst_i = 1'b0;
      stray = 0;
      for (int c = 0; c < 4; c++) begin
         drive(NOP, 32'h504, 0, 0, 8'h00, 32'h8);
         if (csr_we_o || hold_flag_o || int_assert_o) stray++;
      end
      chk("rst_seq.quiet_after", stray, 0);

      // interrupt raised during the mcause write is ignored, then blocked by MIE=0
      drive(ECALL, 32'h600, 0, 0, 8'h00, 32'h8);
      drive(NOP,   32'h604, 0, 0, 8'h00, 32'h8);
      drive(NOP,   32'h604, 0, 0, 8'h00, 32'h8);
      drive(NOP,   32'h604, 0, 0, 8'h01, 32'h8);
      chk_all("busy_int.mcause", 1, 1, 12'h342, 32'd11, 0, 32'h0);
      drive(NOP,   32'h604, 0, 0, 8'h01, 32'h80);
      chk_all("busy_int.assert", 1, 0, 12'h000, 32'h0, 1, 32'h400);
      stray = 0;
      for (int c = 0; c < 4; c++) begin
         drive(NOP, 32'h604, 0, 0, 8'h01, 32'h80);
         if (csr_we_o || hold_flag_o || int_assert_o) stray++;
      end
      chk("busy_int.blocked", stray, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
